// File: rtl/lc3b_types.sv
// Shared LC-3b word and mask types plus arbiter port identifiers.
package lc3b_types;

  typedef logic [15:0] lc3b_word;
  typedef logic [1:0]  lc3b_mem_wmask;

  // Which client port owns (or last owned) the physical memory.
  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } arb_port_t;

  localparam lc3b_mem_wmask MASK_FULL = 2'b11;
  localparam lc3b_word      WORD_ZERO = 16'h0000;

endpackage

// File: rtl/arb_req_latch.sv
// Holds the granted request (address, write data, byte mask, op) so the
// physical-memory side never looks at the live client ports.
module arb_req_latch
  import lc3b_types::*;
(
  input  logic          clk,
  input  logic          clr,
  input  logic          load,
  input  lc3b_word      address_in,
  input  lc3b_word      wdata_in,
  input  lc3b_mem_wmask mask_in,
  input  logic          write_in,
  output lc3b_word      address,
  output lc3b_word      wdata,
  output lc3b_mem_wmask mask,
  output logic          write
);

  // Capture on grant; clear is asynchronous so pmem outputs fall with reset.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      address <= WORD_ZERO;
      wdata   <= WORD_ZERO;
      mask    <= 2'b00;
      write   <= 1'b0;
    end else if (load) begin
      address <= address_in;
      wdata   <= wdata_in;
      mask    <= mask_in;
      write   <= write_in;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (instruction read / data read-write) to single physical memory
// arbiter. One transaction in flight; round-robin on simultaneous requests.
module mem_arbiter
  import lc3b_types::*;
(
  input  logic          clk,
  input  logic          rst,
  // port A: instruction fetch, read only
  input  logic          mem_read_a,
  input  lc3b_word      mem_address_a,
  output lc3b_word      mem_rdata_a,
  output logic          mem_resp_a,
  // port B: data, read/write
  input  logic          mem_read_b,
  input  logic          mem_write_b,
  input  lc3b_mem_wmask mem_byte_enable_b,
  input  lc3b_word      mem_address_b,
  input  lc3b_word      mem_wdata_b,
  output lc3b_word      mem_rdata_b,
  output logic          mem_resp_b,
  // physical memory
  output logic          pmem_read,
  output logic          pmem_write,
  output lc3b_word      pmem_address,
  output lc3b_word      pmem_wdata,
  output lc3b_mem_wmask pmem_byte_enable,
  input  lc3b_word      pmem_rdata,
  input  logic          pmem_resp
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_A = 2'd1,
    SERVE_B = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t        state, state_next;
  arb_port_t     last_grant, last_grant_next;
  lc3b_word      rdata_capture;

  logic          req_a, req_b;
  logic          grant_a, grant_b;
  logic          serving;

  lc3b_word      sel_address, sel_wdata;
  lc3b_mem_wmask sel_mask;
  logic          sel_write;

  lc3b_word      lat_address, lat_wdata;
  lc3b_mem_wmask lat_mask;
  logic          lat_write;

  assign req_a   = mem_read_a;
  assign req_b   = mem_read_b | mem_write_b;
  assign serving = (state == SERVE_A) || (state == SERVE_B);

  // State register and round-robin history; reset abandons any transaction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= PORT_B;
    end else begin
      state      <= state_next;
      last_grant <= last_grant_next;
    end
  end

  // Next-state and grant decision; only IDLE arbitrates, DONE never does.
  always_comb begin
    state_next      = state;
    last_grant_next = last_grant;
    grant_a         = 1'b0;
    grant_b         = 1'b0;
    case (state)
      IDLE: begin
        if (req_a && req_b) begin
          if (last_grant == PORT_B) grant_a = 1'b1;
          else                      grant_b = 1'b1;
        end else if (req_a) begin
          grant_a = 1'b1;
        end else if (req_b) begin
          grant_b = 1'b1;
        end
        if (grant_a) begin
          state_next      = SERVE_A;
          last_grant_next = PORT_A;
        end else if (grant_b) begin
          state_next      = SERVE_B;
          last_grant_next = PORT_B;
        end
      end
      SERVE_A, SERVE_B: begin
        if (pmem_resp) state_next = DONE;
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Select the winning port's fields; read+write together counts as write,
  // and reads always present a full mask.
  always_comb begin
    sel_address = mem_address_a;
    sel_wdata   = WORD_ZERO;
    sel_write   = 1'b0;
    sel_mask    = MASK_FULL;
    if (grant_b) begin
      sel_address = mem_address_b;
      sel_wdata   = mem_wdata_b;
      sel_write   = mem_write_b;
      sel_mask    = mem_write_b ? mem_byte_enable_b : MASK_FULL;
    end
  end

  arb_req_latch u_req_latch (
    .clk        (clk),
    .clr        (rst),
    .load       (grant_a | grant_b),
    .address_in (sel_address),
    .wdata_in   (sel_wdata),
    .mask_in    (sel_mask),
    .write_in   (sel_write),
    .address    (lat_address),
    .wdata      (lat_wdata),
    .mask       (lat_mask),
    .write      (lat_write)
  );

  // Capture returned data on the completing cycle of a serve.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_capture <= WORD_ZERO;
    end else if (serving && pmem_resp) begin
      rdata_capture <= pmem_rdata;
    end
  end

  assign pmem_read        = serving & ~lat_write;
  assign pmem_write       = serving &  lat_write;
  assign pmem_address     = lat_address;
  assign pmem_wdata       = lat_wdata;
  assign pmem_byte_enable = lat_mask;

  // The port granted into this DONE is still recorded in last_grant.
  assign mem_resp_a  = (state == DONE) && (last_grant == PORT_A);
  assign mem_resp_b  = (state == DONE) && (last_grant == PORT_B);
  assign mem_rdata_a = mem_resp_a ? rdata_capture : WORD_ZERO;
  assign mem_rdata_b = mem_resp_b ? rdata_capture : WORD_ZERO;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus a randomized
// two-client phase checked against a word-level memory model.
module tb_mem_arbiter;
  import lc3b_types::*;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          mem_read_a = 1'b0;
  lc3b_word      mem_address_a = '0;
  lc3b_word      mem_rdata_a;
  logic          mem_resp_a;
  logic          mem_read_b = 1'b0;
  logic          mem_write_b = 1'b0;
  lc3b_mem_wmask mem_byte_enable_b = '0;
  lc3b_word      mem_address_b = '0;
  lc3b_word      mem_wdata_b = '0;
  lc3b_word      mem_rdata_b;
  logic          mem_resp_b;
  logic          pmem_read, pmem_write;
  lc3b_word      pmem_address, pmem_wdata;
  lc3b_mem_wmask pmem_byte_enable;
  lc3b_word      pmem_rdata;
  logic          pmem_resp;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk               (clk),
    .rst               (rst),
    .mem_read_a        (mem_read_a),
    .mem_address_a     (mem_address_a),
    .mem_rdata_a       (mem_rdata_a),
    .mem_resp_a        (mem_resp_a),
    .mem_read_b        (mem_read_b),
    .mem_write_b       (mem_write_b),
    .mem_byte_enable_b (mem_byte_enable_b),
    .mem_address_b     (mem_address_b),
    .mem_wdata_b       (mem_wdata_b),
    .mem_rdata_b       (mem_rdata_b),
    .mem_resp_b        (mem_resp_b),
    .pmem_read         (pmem_read),
    .pmem_write        (pmem_write),
    .pmem_address      (pmem_address),
    .pmem_wdata        (pmem_wdata),
    .pmem_byte_enable  (pmem_byte_enable),
    .pmem_rdata        (pmem_rdata),
    .pmem_resp         (pmem_resp)
  );

  logic [69:0] all_outs;
  assign all_outs = {pmem_read, pmem_write, pmem_address, pmem_wdata, pmem_byte_enable,
                     mem_resp_a, mem_resp_b, mem_rdata_a, mem_rdata_b};

  typedef struct {
    bit          w;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [1:0]  be;
  } pm_op_t;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          pmem_resp_cyc = -100;
  int          resp_delay = 0;
  bit          rand_delay = 1'b0;
  bit          spur = 1'b0;
  logic [15:0] pm [0:255];
  logic [15:0] ref_mem [0:255];
  pm_op_t      pm_log [$];
  int          order_q [$];
  int          resp_a_cnt = 0, resp_b_cnt = 0;
  int          done_a_cnt = 0, done_b_cnt = 0;
  bit          rand_done_a = 1'b0, rand_done_b = 1'b0;

  task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] nw,
                                        input logic [1:0] be);
    return {be[1] ? nw[15:8] : old[15:8], be[0] ? nw[7:0] : old[7:0]};
  endfunction

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  // Physical memory model: answers a held strobe after resp_delay cycles.
  initial begin : responder
    int     cnt;
    pm_op_t op;
    cnt = 0;
    pmem_resp = 1'b0;
    pmem_rdata = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pmem_resp = 1'b0;
        cnt = 0;
      end else if (pmem_resp) begin
        pmem_resp = 1'b0;
      end else if (spur) begin
        pmem_resp = 1'b1;
        pmem_rdata = 16'hDEAD;
        spur = 1'b0;
      end else if (pmem_read || pmem_write) begin
        if (cnt >= resp_delay) begin
          op.w = pmem_write;
          op.addr = pmem_address;
          op.wdata = pmem_wdata;
          op.be = pmem_byte_enable;
          pm_log.push_back(op);
          if (pmem_write) begin
            pm[pmem_address[7:0]] = merge(pm[pmem_address[7:0]], pmem_wdata, pmem_byte_enable);
            pmem_rdata = 16'($urandom);
          end else begin
            pmem_rdata = pm[pmem_address[7:0]];
          end
          pmem_resp = 1'b1;
          pmem_resp_cyc = cyc;
          cnt = 0;
          if (rand_delay) resp_delay = $urandom_range(0, 3);
        end else begin
          cnt++;
        end
      end
    end
  end

  // Always-on protocol observations.
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      if (mem_resp_a) resp_a_cnt++;
      if (mem_resp_b) resp_b_cnt++;
      check("dual_resp", 80'(mem_resp_a & mem_resp_b), 80'(0));
      check("strobe_excl", 80'(pmem_read & pmem_write), 80'(0));
      if (!mem_resp_a) check("rdata_a_idle", 80'(mem_rdata_a), 80'(0));
      if (!mem_resp_b) check("rdata_b_idle", 80'(mem_rdata_b), 80'(0));
      if (pmem_read) check("read_be", 80'(pmem_byte_enable), 80'(2'b11));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // Port A read; optionally drop the request after drop_after cycles.
  task automatic txn_a(input logic [15:0] addr, input int drop_after);
    bit got;
    got = 1'b0;
    mem_address_a = addr;
    mem_read_a = 1'b1;
    for (int n = 0; n < 80 && !got; n++) begin
      @(negedge clk);
      if (mem_resp_a) begin
        got = 1'b1;
        done_a_cnt++;
        order_q.push_back(0);
        check("a_rdata", 80'(mem_rdata_a), 80'(ref_mem[addr[7:0]]));
        check("a_latency", 80'(cyc - pmem_resp_cyc), 80'(1));
        $display("txn A rd addr=%h data=%h cyc=%0d", addr, mem_rdata_a, cyc);
      end else if (drop_after > 0 && n + 1 >= drop_after) begin
        mem_read_a = 1'b0;
      end
    end
    mem_read_a = 1'b0;
    if (!got) check("a_timeout", 80'(got), 80'(1));
  endtask

  // Port B transaction; rd and wr both set is a write.
  task automatic txn_b(input logic [15:0] addr, input logic [15:0] wdata,
                       input logic [1:0] be, input bit rd, input bit wr);
    bit got;
    got = 1'b0;
    mem_address_b = addr;
    mem_wdata_b = wdata;
    mem_byte_enable_b = be;
    mem_read_b = rd;
    mem_write_b = wr;
    for (int n = 0; n < 80 && !got; n++) begin
      @(negedge clk);
      if (mem_resp_b) begin
        got = 1'b1;
        done_b_cnt++;
        order_q.push_back(1);
        check("b_latency", 80'(cyc - pmem_resp_cyc), 80'(1));
        if (wr) begin
          ref_mem[addr[7:0]] = merge(ref_mem[addr[7:0]], wdata, be);
          $display("txn B wr addr=%h data=%h be=%b cyc=%0d", addr, wdata, be, cyc);
        end else begin
          check("b_rdata", 80'(mem_rdata_b), 80'(ref_mem[addr[7:0]]));
          $display("txn B rd addr=%h data=%h cyc=%0d", addr, mem_rdata_b, cyc);
        end
      end
    end
    mem_read_b = 1'b0;
    mem_write_b = 1'b0;
    if (!got) check("b_timeout", 80'(got), 80'(1));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #1 check("rst_outs", 80'(all_outs), 80'(0));
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin : main
    int na, nb;
    for (int i = 0; i < 256; i++) begin
      pm[i] = 16'($urandom);
      ref_mem[i] = pm[i];
    end

    // Reset with A already requesting.
    mem_read_a = 1'b1;
    mem_address_a = 16'h0022;
    repeat (2) @(negedge clk);
    check("rst_hold_outs", 80'(all_outs), 80'(0));
    rst = 1'b0;
    @(negedge clk);
    check("rst_first_strobe", 80'({pmem_read, pmem_write}), 80'(2'b10));
    check("rst_first_addr", 80'(pmem_address), 80'(16'h0022));
    txn_a(16'h0022, 0);

    // Single A read with a 3-cycle memory delay.
    resp_delay = 3;
    pm[8'h40] = 16'h1234;
    ref_mem[8'h40] = 16'h1234;
    nb = resp_b_cnt;
    @(negedge clk);
    txn_a(16'h0040, 0);
    check("single_a_no_resp_b", 80'(resp_b_cnt - nb), 80'(0));

    // Tie after reset: A first; A re-requests at once, so B wins the next tie.
    do_reset();
    resp_delay = 1;
    pm_log.delete();
    order_q.delete();
    @(negedge clk);
    fork
      begin
        txn_a(16'h0010, 0);
        txn_a(16'h0011, 0);
      end
      txn_b(16'h0012, 16'h5A5A, 2'b01, 1'b0, 1'b1);
    join
    check("tie_count", 80'(order_q.size()), 80'(3));
    if (order_q.size() == 3) begin
      check("tie_first", 80'(order_q[0]), 80'(0));
      check("tie_second", 80'(order_q[1]), 80'(1));
      check("tie_third", 80'(order_q[2]), 80'(0));
    end
    check("tie_log_count", 80'(pm_log.size()), 80'(3));
    if (pm_log.size() == 3) begin
      check("tie_b_w", 80'(pm_log[1].w), 80'(1));
      check("tie_b_wdata", 80'(pm_log[1].wdata), 80'(16'h5A5A));
      check("tie_b_be", 80'(pm_log[1].be), 80'(2'b01));
      check("tie_b_addr", 80'(pm_log[1].addr), 80'(16'h0012));
    end

    // High-byte write, then read back the merged word.
    pm_log.delete();
    resp_delay = 2;
    @(negedge clk);
    txn_b(16'h0101, 16'hAB00, 2'b10, 1'b0, 1'b1);
    check("bytew_log_count", 80'(pm_log.size()), 80'(1));
    if (pm_log.size() == 1) begin
      check("bytew_w", 80'(pm_log[0].w), 80'(1));
      check("bytew_be", 80'(pm_log[0].be), 80'(2'b10));
      check("bytew_addr", 80'(pm_log[0].addr), 80'(16'h0101));
      check("bytew_wdata", 80'(pm_log[0].wdata), 80'(16'hAB00));
    end
    txn_a(16'h0101, 0);

    // Abort: reset while B waits on memory, then B is served again.
    @(negedge clk);
    resp_delay = 20;
    pm_log.delete();
    mem_address_b = 16'h0033;
    mem_wdata_b = 16'hC3C3;
    mem_byte_enable_b = 2'b11;
    mem_read_b = 1'b0;
    mem_write_b = 1'b1;
    repeat (3) @(negedge clk);
    check("abort_strobe_before", 80'({pmem_read, pmem_write}), 80'(2'b01));
    nb = resp_b_cnt;
    #2 rst = 1'b1;
    #1 check("abort_async_outs", 80'(all_outs), 80'(0));
    @(negedge clk);
    check("abort_resp_b", 80'(mem_resp_b), 80'(0));
    rst = 1'b0;
    resp_delay = 1;
    txn_b(16'h0033, 16'hC3C3, 2'b11, 1'b0, 1'b1);
    check("abort_one_resp", 80'(resp_b_cnt - nb), 80'(1));
    check("abort_log_count", 80'(pm_log.size()), 80'(1));

    // Spurious pmem_resp in IDLE must be ignored.
    @(negedge clk);
    na = resp_a_cnt;
    nb = resp_b_cnt;
    spur = 1'b1;
    repeat (4) @(negedge clk);
    check("spur_no_resp_a", 80'(resp_a_cnt - na), 80'(0));
    check("spur_no_resp_b", 80'(resp_b_cnt - nb), 80'(0));
    check("spur_no_strobe", 80'({pmem_read, pmem_write}), 80'(0));

    // Dropped A request still completes with exactly one resp.
    resp_delay = 3;
    na = resp_a_cnt;
    txn_a(16'h0050, 2);
    repeat (3) @(negedge clk);
    check("drop_one_resp", 80'(resp_a_cnt - na), 80'(1));

    // read_b and write_b together: write only.
    pm_log.delete();
    resp_delay = 0;
    txn_b(16'h0060, 16'h7788, 2'b11, 1'b1, 1'b1);
    check("both_log_count", 80'(pm_log.size()), 80'(1));
    if (pm_log.size() == 1) check("both_is_write", 80'(pm_log[0].w), 80'(1));
    txn_a(16'h0060, 0);

    // Randomized two-client traffic.
    rand_delay = 1'b1;
    fork
      begin
        for (int k = 0; k < 50; k++) begin
          repeat ($urandom_range(0, 3)) @(negedge clk);
          txn_a(16'($urandom_range(0, 15)), 0);
        end
        rand_done_a = 1'b1;
      end
      begin
        int op;
        for (int k = 0; k < 50; k++) begin
          repeat ($urandom_range(0, 3)) @(negedge clk);
          op = $urandom_range(0, 2);
          txn_b(16'($urandom_range(0, 15)), 16'($urandom), 2'($urandom_range(1, 3)),
                op != 1, op != 0);
        end
        rand_done_b = 1'b1;
      end
      begin
        bit must_valid;
        int must;
        int served;
        must_valid = 1'b0;
        must = 0;
        while (!(rand_done_a && rand_done_b)) begin
          @(negedge clk);
          if (mem_resp_a || mem_resp_b) begin
            served = mem_resp_b ? 1 : 0;
            if (must_valid) check("rr_order", 80'(served), 80'(must));
            must_valid = served == 1 ? mem_read_a : (mem_read_b | mem_write_b);
            must = 1 - served;
          end
        end
      end
    join

    repeat (3) @(negedge clk);
    check("resp_a_total", 80'(resp_a_cnt), 80'(done_a_cnt));
    check("resp_b_total", 80'(resp_b_cnt), 80'(done_b_cnt));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 clk  input  1  single clock; all state updates on its rising edge.
REQ-002 rst  input  1  asynchronous, active-high reset.
REQ-003 mem_read_a  input  1  instruction-port read request; held until mem_resp_a.
REQ-004 mem_address_a  input  16  instruction-port word address.
REQ-005 mem_rdata_a  output  16  instruction-port read data; valid only while mem_resp_a=1.
REQ-006 mem_resp_a  output  1  instruction-port completion pulse.
REQ-007 mem_read_b / mem_write_b  input  1 each  data-port read and write requests; held until mem_resp_b.
REQ-008 mem_byte_enable_b  input  2  data-port write byte mask; bit0 = low byte, bit1 = high byte.
REQ-009 mem_address_b, mem_wdata_b  input  16 each  data-port address and write data.
REQ-010 mem_rdata_b  output  16  data-port read data; valid only while mem_resp_b=1.
REQ-011 mem_resp_b  output  1  data-port completion pulse.
REQ-012 pmem_read / pmem_write  output  1 each  physical-memory strobes.
REQ-013 pmem_address, pmem_wdata  output  16 each; pmem_byte_enable  output  2.
REQ-014 pmem_rdata  input  16; pmem_resp  input  1  physical-memory completion.

Function
REQ-015 The block SHALL serialize port A (read-only) and port B (read/write) onto the single pmem interface, with at most one outstanding transaction.
REQ-016 FSM states SHALL be IDLE, SERVE_A, SERVE_B and DONE.
REQ-017 In IDLE with exactly one port requesting, the FSM SHALL move to that port's SERVE state on the next edge.
REQ-018 If both ports request in the same IDLE cycle, the grant SHALL go to the port not granted last (round-robin); last_grant resets to B, so A wins the first tie.
REQ-019 On grant, address, wdata, byte mask and the op (read/write) SHALL be latched; pmem outputs SHALL be driven only from these latches.
REQ-020 In SERVE_x, pmem_read or pmem_write (never both) SHALL be held high until pmem_resp=1.
REQ-021 pmem_byte_enable SHALL equal the latched mask on writes and 2'b11 on reads; a port-A grant SHALL always issue a read.
REQ-022 On pmem_resp=1 in SERVE_x, pmem_rdata SHALL be captured, strobes SHALL drop on the next edge, and the FSM SHALL enter DONE.
REQ-023 In DONE, mem_resp_x of the served port SHALL be high for exactly one cycle, with mem_rdata_x = captured data; the FSM SHALL then return to IDLE.
REQ-024 Minimum latency: request seen at cycle 0, strobe at cycle 1, pmem_resp at cycle 1, mem_resp_x at cycle 2; a new grant no earlier than cycle 3.
REQ-025 The DONE cycle SHALL NOT start arbitration, so a requester may drop or change its request after its resp.
REQ-026 mem_read_b and mem_write_b both high SHALL be treated as a write.
REQ-027 pmem_resp while in IDLE or DONE SHALL be ignored.
REQ-028 A request dropped mid-SERVE SHALL still complete, and its resp SHALL still pulse.
REQ-029 The non-granted port's request SHALL stay pending, with its resp low, until served.
REQ-030 mem_rdata_a/b SHALL read 16'h0000 whenever the matching resp is low.

Reset
REQ-031 rst high SHALL immediately force state IDLE, last_grant=B and all outputs to 0 (strobes, resps, rdata, address, wdata, byte_enable), independent of clk.
REQ-032 rst asserted mid-transaction SHALL abandon that transaction with no resp; after rst falls, pending requests SHALL re-arbitrate from IDLE.

Structure
REQ-033 lc3b_word (16-bit) and a new lc3b_mem_wmask (2-bit) SHALL live in lc3b_types; the FSM state enum SHALL be local to mem_arbiter.
REQ-034 Request latching SHALL be a single sub-module, arb_req_latch (address, wdata, mask, op, with load and asynchronous clear); all other logic stays in mem_arbiter.

Verification
REQ-035 Reset: rst=1 with mem_read_a=1 -> all outputs 0 during rst; first strobe pmem_read one cycle after rst falls, pmem_address=mem_address_a.
REQ-036 Single A read: addr_a=16'h0040, pmem returns 16'h1234 with 3-cycle delay -> mem_resp_a one cycle after pmem_resp, rdata_a=16'h1234; resp_b stays 0.
REQ-037 Tie: read_a and write_b both asserted at cycle 0 after reset -> A served first, then B write with pmem_wdata=mem_wdata_b, byte_enable=2'b01; a second tie -> B first.
REQ-038 Byte write: write_b, addr 16'h0101, wdata 16'hAB00, mask 2'b10 -> pmem_write=1, pmem_byte_enable=2'b10, pmem_read=0 throughout.
REQ-039 Abort: rst pulsed while in SERVE_B awaiting pmem_resp -> strobes drop asynchronously, mem_resp_b never pulses, B re-served after rst falls.
REQ-040 Spurious/drop: pmem_resp=1 in IDLE -> no resp; read_a dropped after grant -> resp_a still pulses once; read_b+write_b both high -> pmem_write only.
